// File: rtl/spi_seq_pkg.sv
// -----------------------------------------------------------------------------
// spi_seq_pkg
// Shared types and constants for the SPI command sequencer.
//   opcode_e : 4-bit command opcodes (values 6..15 are illegal)
//   state_e  : sequencer FSM states
//   err_e    : 2-bit run status reported on err_o
//   CMD_W, OPC_MSB/OPC_LSB, ARG_MSB/ARG_LSB : command word layout
//   max_int  : constant-expression helper used to size the shared timer
// -----------------------------------------------------------------------------
package spi_seq_pkg;

  localparam int CMD_W   = 12;
  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 8;
  localparam int ARG_MSB = 7;
  localparam int ARG_LSB = 0;

  typedef enum logic [3:0] {
    OP_END        = 4'd0,
    OP_CS_ASSERT  = 4'd1,
    OP_CS_RELEASE = 4'd2,
    OP_XFER       = 4'd3,
    OP_XFER_NORX  = 4'd4,
    OP_WAIT       = 4'd5
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_XFER_WAIT = 3'd3,
    ST_DELAY     = 3'd4,
    ST_FINISH    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_OVERRUN = 2'd2,
    ERR_ABORT   = 2'd3
  } err_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// -----------------------------------------------------------------------------
// spi_seq_timer
// Loadable down-counter with zero flag. Shared by the WAIT delay and the
// optional transfer timeout; the sequencer never needs both at once.
// Ports:
//   clk_i     system clock
//   nrst_i    asynchronous active-low reset (count clears to 0)
//   load      load load_val this cycle (has priority over en)
//   load_val  value to load
//   en        decrement while nonzero
//   zero      count is 0
// -----------------------------------------------------------------------------
module spi_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         nrst_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/spi_seq_ctrl.sv
// -----------------------------------------------------------------------------
// spi_seq_ctrl
// Command sequencer for the SPI byte engine. On start_i it walks a command RAM
// from address 0, driving chip select, byte transfers and programmed waits, and
// streams received bytes out. Ends on END, illegal opcode, overrun (last RAM
// word executed without END), abort_i, or (optionally) transfer timeout.
// Ports:
//   clk_i, nrst_i            clock, asynchronous active-low reset
//   start_i, abort_i         run program from address 0 / stop immediately
//   busy_o, done_o, err_o    running, end-of-run pulse, last-run status
//   cmd_addr_o, cmd_data_i   command RAM address / data (1-cycle read latency)
//   eng_cs_o, eng_start_o,
//   eng_tx_o, eng_done_i,
//   eng_rx_i                 SPI byte engine handshake
//   rx_valid_o, rx_data_o    received byte stream
// Configuration macro:
//   SPI_SEQ_TIMEOUT_EN  when defined, a transfer with no eng_done_i for
//                       TIMEOUT_CYCLES cycles ends the run with status 3.
// -----------------------------------------------------------------------------
module spi_seq_ctrl
  import spi_seq_pkg::*;
#(
  parameter int CMD_DEPTH      = 16,
  parameter int WAIT_UNIT      = 100,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int AW            = $clog2(CMD_DEPTH)
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       err_o,
  output logic [AW-1:0]    cmd_addr_o,
  input  logic [CMD_W-1:0] cmd_data_i,
  output logic             eng_cs_o,
  output logic             eng_start_o,
  output logic [7:0]       eng_tx_o,
  input  logic             eng_done_i,
  input  logic [7:0]       eng_rx_i,
  output logic             rx_valid_o,
  output logic [7:0]       rx_data_o
);

  // Timer must hold the longest WAIT (255 units) and the transfer timeout.
  localparam int TMR_MAX = max_int(255 * WAIT_UNIT, TIMEOUT_CYCLES);
  localparam int TW      = $clog2(TMR_MAX + 1);

  state_e        state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  err_e          err_reg, err_next;
  logic          cs_reg, cs_next;
  logic [7:0]    tx_reg, tx_next;
  logic          start_reg, start_next;
  logic          rx_en_reg, rx_en_next;
  logic          rx_valid_reg, rx_valid_next;
  logic [7:0]    rx_data_reg, rx_data_next;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_en;
  logic          tmr_zero;

  opcode_e       opc;
  logic [7:0]    arg;
  logic          last_cmd;
  logic          cmd_complete;
  logic [TW-1:0] wait_load;

  assign opc      = opcode_e'(cmd_data_i[OPC_MSB:OPC_LSB]);
  assign arg      = cmd_data_i[ARG_MSB:ARG_LSB];
  assign last_cmd = (pc_reg == AW'(CMD_DEPTH - 1));
  // Loaded with N-1 so the DELAY state lasts exactly arg*WAIT_UNIT cycles.
  assign wait_load = (TW'(arg) * TW'(WAIT_UNIT)) - TW'(1);

  spi_seq_timer #(
    .W (TW)
  ) u_timer (
    .clk_i    (clk_i),
    .nrst_i   (nrst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  assign tmr_en = (state_reg == ST_DELAY) || (state_reg == ST_XFER_WAIT);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= '0;
      err_reg      <= ERR_OK;
      cs_reg       <= 1'b0;
      tx_reg       <= '0;
      start_reg    <= 1'b0;
      rx_en_reg    <= 1'b0;
      rx_valid_reg <= 1'b0;
      rx_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      err_reg      <= err_next;
      cs_reg       <= cs_next;
      tx_reg       <= tx_next;
      start_reg    <= start_next;
      rx_en_reg    <= rx_en_next;
      rx_valid_reg <= rx_valid_next;
      rx_data_reg  <= rx_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    err_next      = err_reg;
    cs_next       = cs_reg;
    tx_next       = tx_reg;
    start_next    = 1'b0;
    rx_en_next    = rx_en_reg;
    rx_valid_next = 1'b0;
    rx_data_next  = rx_data_reg;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    cmd_complete  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          state_next = ST_FETCH;
          pc_next    = '0;
          err_next   = ERR_OK;
        end
      end
      ST_FETCH: begin
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        case (opc)
          OP_END: state_next = ST_FINISH;
          OP_CS_ASSERT: begin
            cs_next      = 1'b1;
            cmd_complete = 1'b1;
          end
          OP_CS_RELEASE: begin
            cs_next      = 1'b0;
            cmd_complete = 1'b1;
          end
          OP_XFER, OP_XFER_NORX: begin
            tx_next    = arg;
            start_next = 1'b1;
            rx_en_next = (opc == OP_XFER);
            state_next = ST_XFER_WAIT;
`ifdef SPI_SEQ_TIMEOUT_EN
            tmr_load   = 1'b1;
            tmr_val    = TW'(TIMEOUT_CYCLES - 1);
`endif
          end
          OP_WAIT: begin
            if (arg == 8'd0) begin
              cmd_complete = 1'b1;
            end else begin
              tmr_load   = 1'b1;
              tmr_val    = wait_load;
              state_next = ST_DELAY;
            end
          end
          default: begin
            err_next   = ERR_ILLEGAL;
            state_next = ST_FINISH;
          end
        endcase
      end
      ST_XFER_WAIT: begin
        if (eng_done_i) begin
          rx_valid_next = rx_en_reg;
          if (rx_en_reg) begin
            rx_data_next = eng_rx_i;
          end
          cmd_complete = 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
        end else if (tmr_zero) begin
          err_next   = ERR_ABORT;
          state_next = ST_FINISH;
`endif
        end
      end
      ST_DELAY: begin
        if (tmr_zero) begin
          cmd_complete = 1'b1;
        end
      end
      ST_FINISH: begin
        cs_next    = 1'b0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // pc never wraps: finishing the last RAM word without END is an overrun.
    if (cmd_complete) begin
      if (last_cmd) begin
        err_next   = ERR_OVERRUN;
        state_next = ST_FINISH;
      end else begin
        pc_next    = pc_reg + AW'(1);
        state_next = ST_FETCH;
      end
    end

    // Abort overrides everything in an active run. FINISH is excluded: the run
    // is already ending there and a second done_o pulse must not be produced.
    if (abort_i && (state_reg != ST_IDLE) && (state_reg != ST_FINISH)) begin
      err_next      = ERR_ABORT;
      start_next    = 1'b0;
      rx_valid_next = 1'b0;
      rx_data_next  = rx_data_reg;
      pc_next       = pc_reg;
      tmr_load      = 1'b0;
      state_next    = ST_FINISH;
    end
  end

  assign busy_o      = (state_reg != ST_IDLE);
  assign done_o      = (state_reg == ST_FINISH);
  assign err_o       = err_reg;
  assign cmd_addr_o  = pc_reg;
  assign eng_cs_o    = cs_reg;
  assign eng_start_o = start_reg;
  assign eng_tx_o    = tx_reg;
  assign rx_valid_o  = rx_valid_reg;
  assign rx_data_o   = rx_data_reg;

endmodule

// File: tb/tb_spi_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_seq_ctrl
// Self-checking bench for spi_seq_ctrl: a vector table of whole programs with
// hand-computed outcomes, plus hand-written sequences for wait timing, abort,
// start/abort collision, idle abort, transfer hang/timeout and mid-run reset.
// The command RAM and a byte engine that echoes ~tx are modelled here.
// -----------------------------------------------------------------------------
module tb_spi_seq_ctrl;

  localparam int CMD_DEPTH = 16;
  localparam int AW        = 4;

  logic          clk_i = 1'b0;
  logic          nrst_i;
  logic          start_i;
  logic          abort_i;
  logic          busy_o;
  logic          done_o;
  logic [1:0]    err_o;
  logic [AW-1:0] cmd_addr_o;
  logic [11:0]   cmd_data_i;
  logic          eng_cs_o;
  logic          eng_start_o;
  logic [7:0]    eng_tx_o;
  logic          eng_done_i;
  logic [7:0]    eng_rx_i;
  logic          rx_valid_o;
  logic [7:0]    rx_data_o;

  always #5 clk_i = ~clk_i;

  spi_seq_ctrl #(
    .CMD_DEPTH      (CMD_DEPTH),
    .WAIT_UNIT      (100),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk_i       (clk_i),
    .nrst_i      (nrst_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .cmd_addr_o  (cmd_addr_o),
    .cmd_data_i  (cmd_data_i),
    .eng_cs_o    (eng_cs_o),
    .eng_start_o (eng_start_o),
    .eng_tx_o    (eng_tx_o),
    .eng_done_i  (eng_done_i),
    .eng_rx_i    (eng_rx_i),
    .rx_valid_o  (rx_valid_o),
    .rx_data_o   (rx_data_o)
  );

  // Command RAM model with one-cycle registered read.
  logic [11:0] ram [CMD_DEPTH];
  always @(posedge clk_i) cmd_data_i <= ram[cmd_addr_o];

  // Byte engine model: done eng_lat cycles after start, rx = ~tx; 0 = never.
  int eng_lat = 0;
  initial begin
    eng_done_i = 1'b0;
    eng_rx_i   = '0;
    forever begin
      @(negedge clk_i);
      eng_done_i = 1'b0;
      if (eng_lat > 0 && eng_start_o) begin
        for (int k = 1; k < eng_lat; k++) @(negedge clk_i);
        eng_rx_i   = ~eng_tx_o;
        eng_done_i = 1'b1;
      end
    end
  end

  // Cumulative event monitor; the main sequence works with deltas.
  int         tot_start = 0, tot_cs_low = 0, tot_rx = 0, tot_done = 0;
  logic [7:0] rx_buf [64];
  initial begin
    forever begin
      @(negedge clk_i);
      if (eng_start_o) begin
        tot_start++;
        if (!eng_cs_o) tot_cs_low++;
      end
      if (rx_valid_o) begin
        rx_buf[tot_rx % 64] = rx_data_o;
        tot_rx++;
      end
      if (done_o) tot_done++;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic load_prog(input logic [15:0][11:0] prog);
    for (int i = 0; i < CMD_DEPTH; i++) ram[i] = prog[i];
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!done_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check({name, ".done_seen"}, int'(done_o), 1);
  endtask

  // Starts a run; n counts cycles from the first FETCH cycle to done_o.
  task automatic run_prog(input string name, input logic [15:0][11:0] prog,
                          input int lat, output int n);
    load_prog(prog);
    eng_lat = lat;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(name, n);
    repeat (3) @(negedge clk_i);
    #1;
  endtask

  task automatic wait_xfer_start(input string name);
    int n;
    n = 0;
    while (!eng_start_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check({name, ".xfer_started"}, int'(eng_start_o), 1);
  endtask

  typedef struct {
    string            name;
    logic [15:0][11:0] prog;
    int               exp_err;
    int               exp_rx;
    logic [7:0]       exp_rx0;
    logic [7:0]       exp_rx1;
    int               exp_starts;
    int               exp_cs_low;
    int               exp_pc;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  logic [15:0][11:0] p;
  int b_start, b_cs_low, b_rx, b_done, n;

  initial begin
    // ---------------- vector table ----------------
    for (int v = 0; v < NVEC; v++) begin
      vecs[v].prog = '0;  vecs[v].exp_err = 0; vecs[v].exp_rx = 0;
      vecs[v].exp_rx0 = '0; vecs[v].exp_rx1 = '0; vecs[v].exp_starts = 0;
      vecs[v].exp_cs_low = 0; vecs[v].exp_pc = 0;
    end
    // T1: two echoed bytes inside one chip-select window
    vecs[0].name = "t1_xfer2";
    vecs[0].prog[0] = 12'h100; vecs[0].prog[1] = 12'h3A5; vecs[0].prog[2] = 12'h33C;
    vecs[0].prog[3] = 12'h200; vecs[0].prog[4] = 12'h000;
    vecs[0].exp_rx = 2; vecs[0].exp_rx0 = 8'h5A; vecs[0].exp_rx1 = 8'hC3;
    vecs[0].exp_starts = 2; vecs[0].exp_pc = 4;
    // T3: illegal opcode 0xF at address 2
    vecs[1].name = "t3_illegal";
    vecs[1].prog[0] = 12'h100; vecs[1].prog[1] = 12'h311; vecs[1].prog[2] = 12'hF00;
    vecs[1].exp_err = 1; vecs[1].exp_rx = 1; vecs[1].exp_rx0 = 8'hEE;
    vecs[1].exp_starts = 1; vecs[1].exp_pc = 2;
    // T4: 16 XFER_NORX, no END -> overrun
    vecs[2].name = "t4_overrun";
    for (int i = 0; i < 16; i++) vecs[2].prog[i] = 12'h400 | 12'(i);
    vecs[2].exp_err = 2; vecs[2].exp_starts = 16; vecs[2].exp_cs_low = 16; vecs[2].exp_pc = 15;
    // WAIT 0 and a CS_RELEASE no-op
    vecs[3].name = "wait0_relnop";
    vecs[3].prog[0] = 12'h500; vecs[3].prog[1] = 12'h202; vecs[3].prog[2] = 12'h000;
    vecs[3].exp_pc = 2;
    // Double CS_ASSERT, XFER 0xFF
    vecs[4].name = "dbl_cs_xff";
    vecs[4].prog[0] = 12'h101; vecs[4].prog[1] = 12'h101; vecs[4].prog[2] = 12'h3FF;
    vecs[4].prog[3] = 12'h000;
    vecs[4].exp_rx = 1; vecs[4].exp_rx0 = 8'h00; vecs[4].exp_starts = 1; vecs[4].exp_pc = 3;
    // Immediate END
    vecs[5].name = "end_only";
    // Lowest illegal opcode at address 0
    vecs[6].name = "op6_at0";
    vecs[6].prog[0] = 12'h600; vecs[6].exp_err = 1;
    // Illegal at the last address is illegal, not overrun
    vecs[7].name = "illegal_last";
    for (int i = 0; i < 15; i++) vecs[7].prog[i] = 12'h100;
    vecs[7].prog[15] = 12'h700; vecs[7].exp_err = 1; vecs[7].exp_pc = 15;
    // END at the last address is a clean finish
    vecs[8].name = "end_last";
    for (int i = 0; i < 15; i++) vecs[8].prog[i] = 12'h200;
    vecs[8].prog[15] = 12'h000; vecs[8].exp_pc = 15;

    // ---------------- reset state ----------------
    nrst_i  = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    for (int i = 0; i < CMD_DEPTH; i++) ram[i] = '0;
    repeat (3) @(negedge clk_i);
    check("rst.busy", int'(busy_o), 0);
    check("rst.done", int'(done_o), 0);
    check("rst.err", int'(err_o), 0);
    check("rst.addr", int'(cmd_addr_o), 0);
    check("rst.cs", int'(eng_cs_o), 0);
    check("rst.start", int'(eng_start_o), 0);
    check("rst.tx", int'(eng_tx_o), 0);
    check("rst.rx_valid", int'(rx_valid_o), 0);
    check("rst.rx_data", int'(rx_data_o), 0);
    nrst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // ---------------- table-driven programs ----------------
    for (int v = 0; v < NVEC; v++) begin
      b_start = tot_start; b_cs_low = tot_cs_low; b_rx = tot_rx; b_done = tot_done;
      run_prog(vecs[v].name, vecs[v].prog, 3, n);
      check({vecs[v].name, ".err"}, int'(err_o), vecs[v].exp_err);
      check({vecs[v].name, ".starts"}, tot_start - b_start, vecs[v].exp_starts);
      check({vecs[v].name, ".cs_low_starts"}, tot_cs_low - b_cs_low, vecs[v].exp_cs_low);
      check({vecs[v].name, ".rx_cnt"}, tot_rx - b_rx, vecs[v].exp_rx);
      if (vecs[v].exp_rx > 0) check({vecs[v].name, ".rx0"}, int'(rx_buf[b_rx % 64]), int'(vecs[v].exp_rx0));
      if (vecs[v].exp_rx > 1) check({vecs[v].name, ".rx1"}, int'(rx_buf[(b_rx + 1) % 64]), int'(vecs[v].exp_rx1));
      check({vecs[v].name, ".done_cnt"}, tot_done - b_done, 1);
      check({vecs[v].name, ".pc"}, int'(cmd_addr_o), vecs[v].exp_pc);
      check({vecs[v].name, ".cs_end"}, int'(eng_cs_o), 0);
      check({vecs[v].name, ".busy_end"}, int'(busy_o), 0);
      $display("vec %0d %s: err=%0d starts=%0d rx=%0d pc=%0d cycles=%0d", v, vecs[v].name,
               err_o, tot_start - b_start, tot_rx - b_rx, cmd_addr_o, n);
    end

    // ---------------- T2: WAIT 3 timing ----------------
    p = '0; p[0] = 12'h503; p[1] = 12'h000;
    run_prog("t2_wait", p, 3, n);
    // n counts from FETCH; the WAIT decode is one cycle later.
    check_range("t2.wait_cycles", n - 1, 296, 304);
    check("t2.err", int'(err_o), 0);
    $display("t2 wait: done %0d cycles after WAIT decode", n - 1);

    // ---------------- T5: abort during a transfer ----------------
    p = '0; p[0] = 12'h100; p[1] = 12'h312; p[2] = 12'h000;
    load_prog(p);
    eng_lat = 25;
    b_rx = tot_rx; b_done = tot_done;
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    wait_xfer_start("t5");
    check("t5.cs_in_flight", int'(eng_cs_o), 1);
    repeat (5) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    wait_done("t5", n);
    repeat (30) @(negedge clk_i);
    #1;
    check("t5.err", int'(err_o), 3);
    check("t5.rx_cnt", tot_rx - b_rx, 0);
    check("t5.done_cnt", tot_done - b_done, 1);
    check("t5.cs_end", int'(eng_cs_o), 0);
    check("t5.busy_end", int'(busy_o), 0);
    $display("t5 abort: err=%0d rx=%0d", err_o, tot_rx - b_rx);

    // ---------------- start and abort together in IDLE ----------------
    p = '0;
    load_prog(p);
    b_done = tot_done;
    @(negedge clk_i); start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0; abort_i = 1'b0;
    wait_done("start_abort", n);
    repeat (3) @(negedge clk_i);
    #1;
    check("start_abort.err", int'(err_o), 0);
    check("start_abort.done_cnt", tot_done - b_done, 1);
    $display("start+abort in idle: err=%0d", err_o);

    // ---------------- abort in IDLE is ignored ----------------
    b_done = tot_done;
    @(negedge clk_i); abort_i = 1'b1;
    @(negedge clk_i); abort_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check("idle_abort.err", int'(err_o), 0);
    check("idle_abort.busy", int'(busy_o), 0);
    check("idle_abort.done_cnt", tot_done - b_done, 0);
    $display("abort in idle: err=%0d busy=%0d", err_o, busy_o);

    // ---------------- run after abort is clean ----------------
    b_rx = tot_rx;
    run_prog("t5_rerun", vecs[0].prog, 3, n);
    check("t5_rerun.err", int'(err_o), 0);
    check("t5_rerun.rx_cnt", tot_rx - b_rx, 2);
    check("t5_rerun.rx1", int'(rx_buf[(b_rx + 1) % 64]), 8'hC3);
    $display("rerun after abort: err=%0d rx=%0d", err_o, tot_rx - b_rx);

    // ---------------- T6: engine never responds ----------------
    p = '0; p[0] = 12'h3AA; p[1] = 12'h000;
    load_prog(p);
    eng_lat = 0;
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    wait_xfer_start("t6");
`ifdef SPI_SEQ_TIMEOUT_EN
    n = 0;
    while (!done_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check_range("t6.timeout_cycles", n, 1, 66);
    check("t6.err", int'(err_o), 3);
    $display("t6 timeout: done %0d cycles after eng_start", n);
`else
    begin
      int idle_cycles;
      idle_cycles = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk_i);
        if (!busy_o) idle_cycles++;
      end
      check("t6.busy_hold", idle_cycles, 0);
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      wait_done("t6", n);
      #1;
      check("t6.err_after_abort", int'(err_o), 3);
      $display("t6 hang: busy low for %0d of 1000 cycles", idle_cycles);
    end
`endif
    repeat (3) @(negedge clk_i);

    // ---------------- asynchronous reset mid-run ----------------
    p = '0; p[0] = 12'h100; p[1] = 12'h3AB; p[2] = 12'h000;
    load_prog(p);
    eng_lat = 0;
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    wait_xfer_start("mid_rst");
    @(negedge clk_i);
    check("mid_rst.cs_before", int'(eng_cs_o), 1);
    #2 nrst_i = 1'b0;
    #1;
    check("mid_rst.cs", int'(eng_cs_o), 0);
    check("mid_rst.busy", int'(busy_o), 0);
    check("mid_rst.addr", int'(cmd_addr_o), 0);
    check("mid_rst.err", int'(err_o), 0);
    $display("reset mid-run: cs=%0d busy=%0d", eng_cs_o, busy_o);
    @(negedge clk_i);
    nrst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
